// File: rtl/sorted_stream_merger_pkg.sv
// Shared types and defaults for the sorted stream merger.
//   merge_state_t : merge controller states
//   DATA_W_DEF    : default element width
//   CNT_W_DEF     : default element counter width
//   elem_t        : element type at the default width
package merge_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int CNT_W_DEF  = 16;

   typedef logic [DATA_W_DEF-1:0] elem_t;

   typedef enum logic [1:0] {
      S_MERGE   = 2'd0,
      S_DRAIN_A = 2'd1,
      S_DRAIN_B = 2'd2
   } merge_state_t;

   // Stable-merge selection: A wins ties so equal keys keep A-before-B order.
   function automatic logic pick_a(input elem_t a, input elem_t b);
      return (a <= b);
   endfunction

endpackage

// File: rtl/sorted_stream_merger_out_slice.sv
// Single-stage output register for the merged stream.
//   clk, rst   : clock, async active-high reset
//   in_push    : an input element is being accepted this cycle
//   in_data    : element to load
//   in_last    : element closes the merged frame
//   out_ready  : downstream accepts
//   load       : register can take a new element (empty or draining)
//   out_valid, out_data, out_last : registered output stream
module merge_out_slice import merge_pkg::*; #(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_push,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_last,
   input  logic              out_ready,
   output logic              load,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last
);

   // Depends only on registered out_valid and out_ready, so out_valid itself
   // never sees a combinational path from out_ready.
   assign load = !out_valid || out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
      end else if (load) begin
         out_valid <= in_push;
         out_last  <= in_push && in_last;
         if (in_push) begin
            out_data <= in_data;
         end
      end
   end

endmodule

// File: rtl/sorted_stream_merger.sv
// Merges two ascending-sorted frames (streams A and B) into one ascending
// frame on a valid/ready output, one element per cycle at most.
//   clk, rst                          : clock, async active-high reset
//   a_valid, a_data, a_last, a_ready  : input stream A
//   b_valid, b_data, b_last, b_ready  : input stream B
//   out_valid, out_data, out_last     : merged output stream
//   out_ready                         : downstream accepts
//   elem_count                        : elements emitted in current frame
//   busy                              : frame in progress
//   sort_err                          : sticky, an input went out of order
//
// state     | meaning
// S_MERGE   | both streams open, pick the smaller head (ties to A)
// S_DRAIN_A | B finished, pass A through until its last element
// S_DRAIN_B | A finished, pass B through until its last element
module sorted_stream_merger import merge_pkg::*; #(
   parameter int DATA_W = DATA_W_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              a_valid,
   input  logic [DATA_W-1:0] a_data,
   input  logic              a_last,
   output logic              a_ready,
   input  logic              b_valid,
   input  logic [DATA_W-1:0] b_data,
   input  logic              b_last,
   output logic              b_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   input  logic              out_ready,
   output logic [CNT_W-1:0]  elem_count,
   output logic              busy,
   output logic              sort_err
);

   merge_state_t      state;
   logic              load;
   logic              sel_a;
   logic              push;
   logic              push_last;
   logic [DATA_W-1:0] push_data;
   logic              out_hs;
   logic              clr_pending;
   logic [DATA_W-1:0] prev_a;
   logic [DATA_W-1:0] prev_b;
   logic              prev_a_vld;
   logic              prev_b_vld;

   assign sel_a = (a_data <= b_data);

   always_comb begin
      a_ready = 1'b0;
      b_ready = 1'b0;
      case (state)
         S_MERGE: begin
            // Only commit when both heads are visible; never guess on one side.
            if (load && a_valid && b_valid) begin
               a_ready = sel_a;
               b_ready = !sel_a;
            end
         end
         S_DRAIN_A: a_ready = load && a_valid;
         S_DRAIN_B: b_ready = load && b_valid;
         default: begin
            a_ready = 1'b0;
            b_ready = 1'b0;
         end
      endcase
   end

   assign push      = a_ready || b_ready;
   assign push_data = a_ready ? a_data : b_data;
   // The merged frame ends with whichever stream finishes second, which is
   // always the one being drained.
   assign push_last = ((state == S_DRAIN_A) && a_ready && a_last) ||
                      ((state == S_DRAIN_B) && b_ready && b_last);

   merge_out_slice #(
      .DATA_W (DATA_W)
   ) u_out_slice (
      .clk       (clk),
      .rst       (rst),
      .in_push   (push),
      .in_data   (push_data),
      .in_last   (push_last),
      .out_ready (out_ready),
      .load      (load),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_last  (out_last)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_MERGE;
      end else begin
         case (state)
            S_MERGE: begin
               if (a_ready && a_last) begin
                  state <= S_DRAIN_B;
               end else if (b_ready && b_last) begin
                  state <= S_DRAIN_A;
               end
            end
            S_DRAIN_A: begin
               if (a_ready && a_last) begin
                  state <= S_MERGE;
               end
            end
            S_DRAIN_B: begin
               if (b_ready && b_last) begin
                  state <= S_MERGE;
               end
            end
            default: state <= S_MERGE;
         endcase
      end
   end

   assign out_hs = out_valid && out_ready;

   // The count shows the full frame size for one cycle after the closing
   // handshake, then clears. A first element of the next frame handshaking in
   // that same cycle restarts the count at one.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         elem_count  <= '0;
         clr_pending <= 1'b0;
      end else begin
         clr_pending <= out_hs && out_last;
         if (clr_pending) begin
            elem_count <= out_hs ? CNT_W'(1) : '0;
         end else if (out_hs && (elem_count != {CNT_W{1'b1}})) begin
            elem_count <= elem_count + CNT_W'(1);
         end
      end
   end

   // Order check is per stream and per frame: the previous-value flag drops
   // on the stream's last element so a new frame may start low.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev_a     <= '0;
         prev_b     <= '0;
         prev_a_vld <= 1'b0;
         prev_b_vld <= 1'b0;
         sort_err   <= 1'b0;
      end else begin
         if (a_ready) begin
            if (prev_a_vld && (a_data < prev_a)) begin
               sort_err <= 1'b1;
            end
            prev_a     <= a_data;
            prev_a_vld <= !a_last;
         end
         if (b_ready) begin
            if (prev_b_vld && (b_data < prev_b)) begin
               sort_err <= 1'b1;
            end
            prev_b     <= b_data;
            prev_b_vld <= !b_last;
         end
      end
   end

   assign busy = (state != S_MERGE) || out_valid || (elem_count != '0);

endmodule

// File: tb/tb_sorted_stream_merger.sv
module tb_sorted_stream_merger;

   localparam int DW = 32;
   localparam int CW = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          a_valid, a_last, a_ready;
   logic [DW-1:0] a_data;
   logic          b_valid, b_last, b_ready;
   logic [DW-1:0] b_data;
   logic          out_valid, out_last, out_ready;
   logic [DW-1:0] out_data;
   logic [CW-1:0] elem_count;
   logic          busy, sort_err;

   always #5 clk = ~clk;

   sorted_stream_merger #(.DATA_W(DW), .CNT_W(CW)) dut (
      .clk        (clk),
      .rst        (rst),
      .a_valid    (a_valid),
      .a_data     (a_data),
      .a_last     (a_last),
      .a_ready    (a_ready),
      .b_valid    (b_valid),
      .b_data     (b_data),
      .b_last     (b_last),
      .b_ready    (b_ready),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_last   (out_last),
      .out_ready  (out_ready),
      .elem_count (elem_count),
      .busy       (busy),
      .sort_err   (sort_err)
   );

   int n_tests = 0;
   int n_fail  = 0;

   int unsigned qa[$];
   int unsigned qb[$];
   int unsigned exp_q[$];
   int unsigned got[$];
   bit          err_seen;
   bit          exp_sticky;

   typedef struct {
      int          a_len;
      int unsigned a_el [8];
      int          b_len;
      int unsigned b_el [8];
      int          rdy_mode;
      int          exp_len;
      int unsigned exp_el [8];
      bit          exp_err;
   } vec_t;

   vec_t vec [7];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic drive_in(input int vpct, input int rdy_mode, input int phase);
      if (qa.size() > 0) begin
         a_valid = ($urandom_range(99) < vpct);
         a_data  = qa[0];
         a_last  = (qa.size() == 1);
      end else begin
         a_valid = 1'b0;
         a_data  = '0;
         a_last  = 1'b0;
      end
      if (qb.size() > 0) begin
         b_valid = ($urandom_range(99) < vpct);
         b_data  = qb[0];
         b_last  = (qb.size() == 1);
      end else begin
         b_valid = 1'b0;
         b_data  = '0;
         b_last  = 1'b0;
      end
      case (rdy_mode)
         0:       out_ready = 1'b1;
         1:       out_ready = ((phase % 4) == 0) || ((phase % 4) == 3);
         default: out_ready = ($urandom_range(99) < 70);
      endcase
   endtask

   // Reference: plain two-pointer stable merge of the two frames.
   function automatic void ref_merge();
      int i = 0;
      int j = 0;
      exp_q.delete();
      while (i < qa.size() || j < qb.size()) begin
         if (j >= qb.size() || (i < qa.size() && qa[i] <= qb[j])) begin
            exp_q.push_back(qa[i]);
            i++;
         end else begin
            exp_q.push_back(qb[j]);
            j++;
         end
      end
   endfunction

   function automatic bit has_desc(input int unsigned q[$]);
      for (int i = 1; i < q.size(); i++)
         if (q[i] < q[i-1]) return 1'b1;
      return 1'b0;
   endfunction

   // Runs one frame from qa/qb against exp_q. Starts and ends just after a
   // rising edge.
   task automatic run_frame(input string tag, input int rdy_mode, input int vpct, input bit exp_err);
      int          hs_done = 0;
      int          cyc = 0;
      int          a_idx = 0;
      int          b_idx = 0;
      int unsigned a_prev = 0;
      int unsigned b_prev = 0;
      bit          done = 1'b0;
      bit          stall_prev = 1'b0;
      logic [DW-1:0] stall_d = '0;
      logic        stall_l = 1'b0;
      bit          a_hs, b_hs, o_hs;
      int          n;
      got.delete();
      drive_in(vpct, rdy_mode, 0);
      while (!done && cyc < 500) begin
         @(negedge clk);
         cyc++;
         check({tag, " elem_count"}, elem_count, hs_done);
         check({tag, " sort_err"}, sort_err, err_seen);
         if (stall_prev) begin
            check({tag, " stall_valid"}, out_valid, 1);
            check({tag, " stall_data"}, out_data, stall_d);
            check({tag, " stall_last"}, out_last, stall_l);
         end
         if (out_valid && !out_ready) begin
            check({tag, " stall_ready"}, {a_ready, b_ready}, 0);
            stall_prev = 1'b1;
            stall_d    = out_data;
            stall_l    = out_last;
         end else begin
            stall_prev = 1'b0;
         end
         a_hs = a_valid && a_ready;
         b_hs = b_valid && b_ready;
         o_hs = out_valid && out_ready;
         if (a_hs && b_hs) check({tag, " dual_accept"}, 1, 0);
         if (a_hs) begin
            if (a_idx > 0 && a_data < a_prev) err_seen = 1'b1;
            a_prev = a_data;
            a_idx++;
         end
         if (b_hs) begin
            if (b_idx > 0 && b_data < b_prev) err_seen = 1'b1;
            b_prev = b_data;
            b_idx++;
         end
         if (o_hs) begin
            got.push_back(out_data);
            hs_done++;
            if (out_last) done = 1'b1;
         end
         @(posedge clk);
         #1;
         if (a_hs) void'(qa.pop_front());
         if (b_hs) void'(qb.pop_front());
         drive_in(vpct, rdy_mode, cyc);
      end
      check({tag, " frame_done"}, done, 1);
      @(negedge clk);
      check({tag, " count_final"}, elem_count, hs_done);
      check({tag, " busy_final"}, busy, 1);
      check({tag, " sort_err_end"}, sort_err, exp_err);
      @(negedge clk);
      check({tag, " count_clear"}, elem_count, 0);
      check({tag, " busy_idle"}, busy, 0);
      check({tag, " inputs_drained"}, qa.size() + qb.size(), 0);
      check({tag, " out_len"}, got.size(), exp_q.size());
      n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
      for (int i = 0; i < n; i++)
         check($sformatf("%s out[%0d]", tag, i), got[i], exp_q[i]);
      @(posedge clk);
      #1;
   endtask

   initial begin
      vec[0] = '{a_len:5, a_el:'{1,3,5,7,9,0,0,0}, b_len:3, b_el:'{2,4,6,0,0,0,0,0},
                 rdy_mode:0, exp_len:8, exp_el:'{1,2,3,4,5,6,7,9}, exp_err:1'b0};
      vec[1] = '{a_len:2, a_el:'{2,2,0,0,0,0,0,0}, b_len:2, b_el:'{2,5,0,0,0,0,0,0},
                 rdy_mode:0, exp_len:4, exp_el:'{2,2,2,5,0,0,0,0}, exp_err:1'b0};
      vec[2] = '{a_len:5, a_el:'{1,3,5,7,9,0,0,0}, b_len:3, b_el:'{2,4,6,0,0,0,0,0},
                 rdy_mode:1, exp_len:8, exp_el:'{1,2,3,4,5,6,7,9}, exp_err:1'b0};
      vec[3] = '{a_len:1, a_el:'{4,0,0,0,0,0,0,0}, b_len:1, b_el:'{3,0,0,0,0,0,0,0},
                 rdy_mode:0, exp_len:2, exp_el:'{3,4,0,0,0,0,0,0}, exp_err:1'b0};
      vec[4] = '{a_len:1, a_el:'{1,0,0,0,0,0,0,0}, b_len:1, b_el:'{0,0,0,0,0,0,0,0},
                 rdy_mode:0, exp_len:2, exp_el:'{0,1,0,0,0,0,0,0}, exp_err:1'b0};
      vec[5] = '{a_len:3, a_el:'{5,3,8,0,0,0,0,0}, b_len:1, b_el:'{9,0,0,0,0,0,0,0},
                 rdy_mode:0, exp_len:4, exp_el:'{5,3,8,9,0,0,0,0}, exp_err:1'b1};
      vec[6] = '{a_len:1, a_el:'{1,0,0,0,0,0,0,0}, b_len:1, b_el:'{2,0,0,0,0,0,0,0},
                 rdy_mode:0, exp_len:2, exp_el:'{1,2,0,0,0,0,0,0}, exp_err:1'b1};

      rst = 1'b1;
      err_seen = 1'b0;
      exp_sticky = 1'b0;
      qa.delete();
      qb.delete();
      drive_in(100, 0, 0);
      repeat (2) @(negedge clk);
      check("reset out_valid", out_valid, 0);
      check("reset out_data", out_data, 0);
      check("reset out_last", out_last, 0);
      check("reset elem_count", elem_count, 0);
      check("reset busy", busy, 0);
      check("reset sort_err", sort_err, 0);
      check("reset readys", {a_ready, b_ready}, 0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      for (int v = 0; v < 7; v++) begin
         qa.delete();
         qb.delete();
         exp_q.delete();
         for (int i = 0; i < vec[v].a_len; i++) qa.push_back(vec[v].a_el[i]);
         for (int i = 0; i < vec[v].b_len; i++) qb.push_back(vec[v].b_el[i]);
         for (int i = 0; i < vec[v].exp_len; i++) exp_q.push_back(vec[v].exp_el[i]);
         run_frame($sformatf("v%0d", v), vec[v].rdy_mode, 100, vec[v].exp_err);
      end

      // Asynchronous reset in the middle of a frame.
      begin
         int  n_hs = 0;
         int  cyc = 0;
         bit  a_hs, b_hs;
         qa = '{1, 3, 5, 7, 9};
         qb = '{2, 4, 6};
         drive_in(100, 0, 0);
         while (n_hs < 3 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            a_hs = a_valid && a_ready;
            b_hs = b_valid && b_ready;
            if (out_valid && out_ready) n_hs++;
            @(posedge clk);
            #1;
            if (a_hs) void'(qa.pop_front());
            if (b_hs) void'(qb.pop_front());
            drive_in(100, 0, 0);
         end
         check("mid hs_reached", n_hs, 3);
         check("mid pre sort_err", sort_err, 1);
         #2 rst = 1'b1;
         #1;
         check("mid out_valid", out_valid, 0);
         check("mid elem_count", elem_count, 0);
         check("mid busy", busy, 0);
         check("mid sort_err", sort_err, 0);
         check("mid out_last", out_last, 0);
         qa.delete();
         qb.delete();
         drive_in(100, 0, 0);
         @(negedge clk);
         rst = 1'b0;
         err_seen = 1'b0;
         @(posedge clk);
         #1;
         qa = '{1};
         qb = '{2};
         exp_q = '{1, 2};
         run_frame("post_rst", 0, 100, 1'b0);
      end

      // Randomized frames against the reference merge.
      exp_sticky = 1'b0;
      for (int f = 0; f < 40; f++) begin
         int la;
         int lb;
         la = $urandom_range(1, 6);
         lb = $urandom_range(1, 6);
         qa.delete();
         qb.delete();
         for (int i = 0; i < la; i++) qa.push_back($urandom_range(0, 15));
         for (int i = 0; i < lb; i++) qb.push_back($urandom_range(0, 15));
         if ($urandom_range(0, 9) != 0) begin
            qa.sort();
            qb.sort();
         end
         if (has_desc(qa) || has_desc(qb)) exp_sticky = 1'b1;
         ref_merge();
         run_frame($sformatf("rnd%0d", f), 2, 80, exp_sticky);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/sorted_stream_merger.md
Name: sorted_stream_merger

Overview:
- Hardware merge controller: arbitrates a single output stream between two requesters, A and B.
- Each requester delivers one ascending-sorted frame per transaction; the block emits one ascending-sorted merged frame.
- Sits between two sorted-data producers (e.g. sort-unit outputs) and a downstream consumer.
- Uses valid/ready handshakes throughout; one element is moved per cycle at most.

Parameters:
- DATA_W, 32, element width; unsigned compare.
- CNT_W, 16, width of the element counter.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- a_valid  in  1  stream A element valid.
- a_data  in  DATA_W  stream A element.
- a_last  in  1  final element of stream A frame.
- a_ready  out  1  stream A element accepted this cycle.
- b_valid, b_data, b_last, b_ready: same as A, for stream B.
- out_valid  out  1  merged element valid.
- out_data  out  DATA_W  merged element.
- out_last  out  1  final element of merged frame.
- out_ready  in  1  downstream accepts.
- elem_count  out  CNT_W  elements emitted in the current frame, including the one on an accepting handshake.
- busy  out  1  frame in progress.
- sort_err  out  1  sticky: an input stream violated ascending order.

Behaviour:
- Reset is asynchronous, active-high, and applies the same state at any time, including mid-frame:
  - state = S_MERGE; out_valid = 0; out_data = 0; out_last = 0.
  - elem_count = 0; sort_err = 0; busy = 0.
  - Previous-value registers and their valid flags cleared; a partial frame is discarded.
- Output register is a single stage. load = !out_valid || out_ready.
- A transfer occurs only when load = 1. At most one input is accepted per cycle.
- Latency: an accepted input appears on out_data in the next cycle.
- S_MERGE (both streams active):
  - Waits until a_valid && b_valid. Never speculates on a single valid stream.
  - Selects A if a_data <= b_data, else B. Ties go to A (stable merge).
  - Drives ready only on the selected stream.
  - Accepting A with a_last = 1 -> S_DRAIN_B. Accepting B with b_last = 1 -> S_DRAIN_A.
  - out_last = 0 in this state.
- S_DRAIN_A: B is finished.
  - a_ready = load && a_valid; b_ready = 0.
  - Accepting A with a_last = 1 sets out_last = 1 with that element -> S_MERGE.
- S_DRAIN_B: symmetric to S_DRAIN_A.
- Simultaneous a_last and b_last cannot both be consumed in one cycle; the second last is consumed in the drain state.
- Every frame holds at least one element, since last marks an element.
- Ready signals are combinational from state, valids, compare and load. No combinational path from out_ready to out_valid.
- While out_valid && !out_ready: out_data and out_last are held stable, and both readys are 0.
- elem_count:
  - Increments on each out handshake (out_valid && out_ready).
  - Cleared to 0 on the cycle after the out_last handshake.
  - Saturates at all-ones.
- busy = (state != S_MERGE) || out_valid || elem_count != 0.
- sort_err:
  - Each stream keeps its previous accepted value plus a valid flag.
  - An accepted element < previous value sets sort_err.
  - Valid flag clears when that stream's last element is accepted.
  - Cleared only by rst. Merging continues unaffected.

Decomposition:
- Package merge_pkg:
  - Enum merge_state_t {S_MERGE, S_DRAIN_A, S_DRAIN_B}.
  - DATA_W_DEF and CNT_W_DEF localparams.
  - Typedef elem_t as logic [DATA_W_DEF-1:0].
- One sub-module: merge_out_slice.
  - Holds the output register: data, last, valid, load logic.
  - The parent holds the FSM, select compare, readys, counters and error check.

Test Plan:
- A={1,3,5,7,9}, B={2,4,6}, out_ready=1 -> out 1,2,3,4,5,6,7,9; out_last only on 9; elem_count reaches 8, then returns to 0; sort_err = 0.
- Tie: A={2,2}, B={2,5} -> out 2(A),2(A),2(B),5; out_last on 5; a_ready pulses precede b_ready.
- Backpressure: same as test 1 with out_ready toggling 1,0,0,1 -> out_data/out_last stable while stalled; no element lost or duplicated; a_ready = b_ready = 0 during stall.
- Single-element frames: A={4}, B={3} -> out 3, 4; out_last on 4; state path S_MERGE -> S_DRAIN_A -> S_MERGE; back-to-back second frame A={1}, B={0} merges correctly.
- Unsorted input: A={5,3,8}, B={9} -> out 5,3,8,9 in this exact order (3 is accepted before 9); sort_err rises the cycle after 3 is accepted and stays 1 across the next frame.
- Reset mid-frame: assert rst after 3 outputs of test 1 -> out_valid, elem_count, busy, sort_err = 0 immediately (asynchronous); a fresh A={1}, B={2} afterwards yields 1, 2 with out_last on 2.
